drm_metering_scheduler: RTL
===========================

Name: drm_metering_scheduler

Overview:
- Shares one DRM activator metering-event port between NUM_REQ kernel requesters.
- Gates each requester's enable from the activator's activation code and demo mode.
- Keeps a saturating pending-event count per requester and issues metering events round-robin over a valid/ready handshake, with a minimum gap between events.
- Sits between the user kernels and the activator-side metering adapter in the DRM HDK wrapper.

Parameters:
- NUM_REQ, 4, number of requesters (1..16)
- CNT_W, 8, width of each pending-event counter
- CODE_W, 128, activation code width
- CODE_BIT_BASE, 0, code bit index that enables requester 0; requester i uses bit CODE_BIT_BASE+i
- MIN_GAP, 2, minimum idle cycles between an accepted event and the next meter_valid (0 allowed)

Ports:
- drm_aclk  in  1  clock
- drm_arst  in  1  asynchronous reset, active-high
- activation_code_ready  in  1  activation code valid from activator
- activation_code  in  CODE_W  activation code
- demo_mode  in  1  activator demo mode
- usage_event  in  NUM_REQ  single-cycle usage pulse per requester
- req_enable  out  NUM_REQ  registered per-requester run enable
- meter_valid  out  1  metering event offered
- meter_ready  in  1  adapter accepts event
- meter_id  out  IDW  requester index of offered event; IDW = max(1, clog2(NUM_REQ))
- pending_overflow  out  NUM_REQ  sticky counter-saturation flag
- busy  out  1  meter_valid OR any counter nonzero

Behaviour:
- Reset (async, any time, including mid-handshake): all outputs 0, counters 0, state WAIT_CODE, rr pointer = NUM_REQ-1, gap counter 0.
- FSM:
  - WAIT_CODE -> ACTIVE when activation_code_ready=1.
  - ACTIVE -> HOLD when activation_code_ready=0.
  - HOLD -> ACTIVE when activation_code_ready=1.
  - WAIT_CODE is never re-entered except by reset.
- req_enable[i] registered, 1-cycle latency: (next state == ACTIVE) AND (activation_code[CODE_BIT_BASE+i] OR demo_mode). In WAIT_CODE and HOLD it is 0.
- Counters:
  - usage_event[i] increments cnt[i] only if req_enable[i]=1 in the same cycle; otherwise the pulse is dropped.
  - Increment and accept-decrement on the same requester in the same cycle: count unchanged.
  - Increment at all-ones: count stays, pending_overflow[i] set. It is cleared only by reset.
- Issue:
  - Condition: state ACTIVE, meter_valid=0, gap counter=0, and some cnt nonzero (registered value).
  - The scheduler picks the first nonzero index after the rr pointer, wrapping modulo NUM_REQ.
  - It asserts meter_valid and meter_id in the next cycle.
  - Latency: usage pulse at cycle t -> count at t+1 -> meter_valid at t+2 (minimum).
- Handshake:
  - Once asserted, meter_valid and meter_id are held stable until meter_ready. This holds even through HOLD; no retraction.
  - On accept (valid and ready): decrement cnt[meter_id], rr pointer = meter_id, gap counter = MIN_GAP, meter_valid = 0 next cycle.
  - The gap counter decrements to 0 while idle; with MIN_GAP=0, back-to-back events arrive every 2 cycles.
- The counter never goes below 0; a count that is offered is guaranteed nonzero.
- In HOLD, pending counts are retained and no new events are issued. Issue resumes after returning to ACTIVE.

Decomposition:
- Package drm_metering_scheduler_pkg holds:
  - state enum (WAIT_CODE, ACTIVE, HOLD)
  - IDW function
  - default parameter constants
- Sub-module drm_rr_picker: combinational round-robin first-set-after-pointer over NUM_REQ bits, returning index and found flag.

Test Plan:
- Reset, activation_code_ready=1, code=0x5, demo=0 -> req_enable=4'b0101 after 1 cycle; WAIT_CODE->ACTIVE; usage_event on req 1 is dropped, cnt[1]=0.
- Req 0 and req 2 each pulse 3 times, meter_ready=1, MIN_GAP=2 -> 6 events, ids 0,2,0,2,0,2; 3 idle cycles between valids; busy drops after the last accept.
- meter_ready=0 for 10 cycles while valid, activation_code_ready dropped mid-wait -> valid and id stable; req_enable=0; after ready, no new issue until code ready again; remaining counts then drain.
- CNT_W=2, 5 pulses on req 0 with ready=0 -> cnt saturates at 3, pending_overflow[0]=1; after draining, exactly 3 events issued; flag still 1.
- Same-cycle usage_event[0] and accept of id 0 with cnt=1 -> cnt stays 1, one further event issued.
- drm_arst asserted while meter_valid=1 -> all outputs 0 immediately; after release, WAIT_CODE; pending events lost.

Source files
------------

// File: rtl/drm_metering_scheduler_pkg.sv
// Shared types and defaults for the DRM metering-event scheduler.
// Also holds the id-width helper used by the top and the round-robin picker.
package drm_metering_scheduler_pkg;

  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_CNT_W         = 8;
  localparam int DEF_CODE_W        = 128;
  localparam int DEF_CODE_BIT_BASE = 0;
  localparam int DEF_MIN_GAP       = 2;

  typedef enum logic [1:0] {
    WAIT_CODE = 2'd0,
    ACTIVE    = 2'd1,
    HOLD      = 2'd2
  } sched_state_e;

  // A single requester still needs one bit to carry its id.
  function automatic int idWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/drm_metering_scheduler_rr_picker.sv
// Combinational round-robin picker: returns the first set bit strictly after
// the pointer, wrapping modulo NUM_REQ, plus a found flag.
module drm_rr_picker
  import drm_metering_scheduler_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDW     = idWidth(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [IDW-1:0]     idx_o,
  output logic               found_o
);

  // Scan from the farthest offset down so the nearest candidate wins last.
  always_comb begin
    int j;
    j       = 0;
    idx_o   = '0;
    found_o = 1'b0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      j = (int'(ptr_i) + off) % NUM_REQ;
      if (req_i[j]) begin
        idx_o   = IDW'(j);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/drm_metering_scheduler.sv
// Shares one DRM activator metering-event port between NUM_REQ kernels:
// gates requester enables, counts pending usage and issues events round-robin.
module drm_metering_scheduler
  import drm_metering_scheduler_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int CODE_W        = DEF_CODE_W,
  parameter int CODE_BIT_BASE = DEF_CODE_BIT_BASE,
  parameter int MIN_GAP       = DEF_MIN_GAP,
  localparam int IDW          = idWidth(NUM_REQ)
) (
  input  logic               drm_aclk,
  input  logic               drm_arst,
  input  logic               activation_code_ready,
  input  logic [CODE_W-1:0]  activation_code,
  input  logic               demo_mode,
  input  logic [NUM_REQ-1:0] usage_event,
  output logic [NUM_REQ-1:0] req_enable,
  output logic               meter_valid,
  input  logic               meter_ready,
  output logic [IDW-1:0]     meter_id,
  output logic [NUM_REQ-1:0] pending_overflow,
  output logic               busy
);

  localparam int GAP_W = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);

  localparam logic [1:0] S_WAIT_CODE = 2'(WAIT_CODE);
  localparam logic [1:0] S_ACTIVE    = 2'(ACTIVE);
  localparam logic [1:0] S_HOLD      = 2'(HOLD);

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] reqEnable_q, reqEnable_d;
  logic [CNT_W-1:0]   cnt_q [NUM_REQ];
  logic [CNT_W-1:0]   cnt_d [NUM_REQ];
  logic [NUM_REQ-1:0] overflow_q, overflow_d;
  logic               meterValid_q, meterValid_d;
  logic [IDW-1:0]     meterId_q, meterId_d;
  logic [IDW-1:0]     rrPtr_q, rrPtr_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic [NUM_REQ-1:0] nonZero;
  logic [NUM_REQ-1:0] incVec;
  logic [NUM_REQ-1:0] decVec;
  logic [IDW-1:0]     pickIdx;
  logic               pickFound;
  logic               accept;
  logic               issue;
  logic               unusedCode;

  // Only CODE_BIT_BASE..+NUM_REQ-1 of the activation code gate requesters.
  assign unusedCode = ^activation_code;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_CODE: if (activation_code_ready)  state_d = S_ACTIVE;
      S_ACTIVE:    if (!activation_code_ready) state_d = S_HOLD;
      S_HOLD:      if (activation_code_ready)  state_d = S_ACTIVE;
      default:     state_d = S_WAIT_CODE;
    endcase
  end

  assign reqEnable_d = (state_d == S_ACTIVE)
                     ? (activation_code[CODE_BIT_BASE +: NUM_REQ] | {NUM_REQ{demo_mode}})
                     : '0;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      nonZero[i] = |cnt_q[i];
      incVec[i]  = usage_event[i] & reqEnable_q[i];
      decVec[i]  = accept && (meterId_q == IDW'(i));
    end
  end

  drm_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .req_i   (nonZero),
    .ptr_i   (rrPtr_q),
    .idx_o   (pickIdx),
    .found_o (pickFound)
  );

  assign accept = meterValid_q & meter_ready;
  assign issue  = (state_q == S_ACTIVE) & ~meterValid_q & (gap_q == '0) & pickFound;

  // A simultaneous increment and accept cancel out, so they never overflow.
  always_comb begin
    overflow_d = overflow_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (incVec[i] && !decVec[i]) begin
        if (&cnt_q[i]) overflow_d[i] = 1'b1;
        else           cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (decVec[i] && !incVec[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // An offered event is never retracted; the gap only runs down while idle.
  always_comb begin
    meterValid_d = meterValid_q;
    meterId_d    = meterId_q;
    rrPtr_d      = rrPtr_q;
    gap_d        = gap_q;
    if (accept) begin
      meterValid_d = 1'b0;
      rrPtr_d      = meterId_q;
      gap_d        = GAP_W'(MIN_GAP);
    end else if (issue) begin
      meterValid_d = 1'b1;
      meterId_d    = pickIdx;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GAP_W'(1);
    end
  end

  always_ff @(posedge drm_aclk or posedge drm_arst) begin
    if (drm_arst) begin
      state_q      <= S_WAIT_CODE;
      reqEnable_q  <= '0;
      overflow_q   <= '0;
      meterValid_q <= 1'b0;
      meterId_q    <= '0;
      rrPtr_q      <= IDW'(NUM_REQ - 1);
      gap_q        <= '0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      reqEnable_q  <= reqEnable_d;
      overflow_q   <= overflow_d;
      meterValid_q <= meterValid_d;
      meterId_q    <= meterId_d;
      rrPtr_q      <= rrPtr_d;
      gap_q        <= gap_d;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign req_enable       = reqEnable_q;
  assign meter_valid      = meterValid_q;
  assign meter_id         = meterId_q;
  assign pending_overflow = overflow_q;
  assign busy             = meterValid_q | (|nonZero);

endmodule
